// File: rtl/arm_shift_pkg.sv
// Shared shift-type encodings, the decoded-operation record and the amount
// normaliser used by the operand-2 shifter pipeline.
package arm_shift_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Normalised amounts never exceed WIDTH+1, so 16 bits covers any sane WIDTH.
    localparam int NAMT_W = 16;

    typedef struct packed {
        logic [NAMT_W-1:0] amt;
        logic              rrx;
        logic              pass;
    } dec_t;

    function automatic dec_t decode(input logic [1:0]        typ,
                                    input logic              is_dpis,
                                    input logic [NAMT_W-1:0] amt,
                                    input int                width);
        dec_t d;
        d = '{amt: '0, rrx: 1'b0, pass: 1'b0};
        if (amt == '0) begin
            if (!is_dpis || typ == SH_LSL)
                d.pass = 1'b1;
            else if (typ == SH_ROR)
                d.rrx = 1'b1;
            else
                d.amt = NAMT_W'(width);
        end else if (typ == SH_ROR) begin
            // Rotates wrap, so keep amt mod width; a full turn is encoded as width.
            d.amt = amt & NAMT_W'(width - 1);
            if (d.amt == '0)
                d.amt = NAMT_W'(width);
        end else if (amt > NAMT_W'(width)) begin
            d.amt = NAMT_W'(width + 1);
        end else begin
            d.amt = amt;
        end
        return d;
    endfunction

endpackage

// File: rtl/arm_shift_core.sv
// Combinational barrel shifter: decoded operation in, {carry_out, value} out.
module arm_shift_core
    import arm_shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       typ,
    input  dec_t             dec,
    input  logic [WIDTH-1:0] data,
    input  logic             c,
    output logic [WIDTH:0]   res
);

    logic [WIDTH:0]   lsl_t;
    logic [WIDTH:0]   lsr_t;
    logic [WIDTH:0]   asr_t;
    logic [WIDTH-1:0] ror_v;

    // Extra guard bit catches the last bit shifted out as the carry.
    assign lsl_t = {1'b0, data} << dec.amt;
    assign lsr_t = {data, 1'b0} >> dec.amt;
    assign asr_t = $unsigned($signed({data, 1'b0}) >>> dec.amt);
    assign ror_v = WIDTH'({data, data} >> dec.amt);

    always_comb begin
        // NOTE: default first so every path assigns res and no latch is inferred.
        res = {c, data};
        if (dec.pass) begin
            res = {c, data};
        end else if (dec.rrx) begin
            res = {data[0], c, data[WIDTH-1:1]};
        end else begin
            case (typ)
                SH_LSL:  res = lsl_t;
                SH_LSR:  res = {lsr_t[0], lsr_t[WIDTH:1]};
                SH_ASR:  res = {asr_t[0], asr_t[WIDTH:1]};
                default: res = {ror_v[WIDTH-1], ror_v};
            endcase
        end
    end

endmodule

// File: rtl/arm_shift_pipe.sv
// Two-stage valid/ready operand-2 shifter: decode/normalise, then shift.
module arm_shift_pipe
    import arm_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_type,
    input  logic             in_is_dpis,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_c,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_res,
    output logic [TAG_W-1:0] out_tag
);

    logic             s1_valid;
    logic [1:0]       s1_type;
    dec_t             s1_dec;
    logic [WIDTH-1:0] s1_data;
    logic             s1_c;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid;
    logic             s2_load;
    logic             s1_advance;
    logic [WIDTH:0]   core_res;

    assign s2_load    = !s2_valid || out_ready;
    assign s1_advance = s1_valid && s2_load;
    assign in_ready   = !s1_valid || s1_advance;
    assign out_valid  = s2_valid;

    // NOTE: <= so every register samples pre-edge values and stage order cannot race.
    always_ff @(posedge clk) begin
        if (reset)
            s1_valid <= 1'b0;
        else if (in_ready)
            s1_valid <= in_valid;
    end

    // NOTE: stage-1 payload is left unreset; s1_valid alone says whether it means anything.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_type <= in_type;
            s1_dec  <= decode(in_type, in_is_dpis, NAMT_W'(in_amt), WIDTH);
            s1_data <= in_data;
            s1_c    <= in_c;
            s1_tag  <= in_tag;
        end
    end

    arm_shift_core #(.WIDTH(WIDTH)) u_core (
        .typ  (s1_type),
        .dec  (s1_dec),
        .data (s1_data),
        .c    (s1_c),
        .res  (core_res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            out_res  <= '0;
            out_tag  <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_res <= core_res;
                out_tag <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_arm_shift_pipe.sv
// Scoreboard bench for arm_shift_pipe: directed corner cases, a stalled random
// stream, mid-flight reset and a 16-bit instance.
module tb_arm_shift_pipe;
    import arm_shift_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_ready, in_is_dpis = 1'b0, in_c = 1'b0;
    logic [1:0]  in_type = 2'b00;
    logic [7:0]  in_amt = '0;
    logic [31:0] in_data = '0;
    logic [3:0]  in_tag = '0, out_tag;
    logic        out_valid, out_ready = 1'b0;
    logic [32:0] out_res;

    logic        in_valid_16 = 1'b0, in_ready_16, in_is_dpis_16 = 1'b0, in_c_16 = 1'b0;
    logic [1:0]  in_type_16 = 2'b00;
    logic [7:0]  in_amt_16 = '0;
    logic [15:0] in_data_16 = '0;
    logic [3:0]  in_tag_16 = '0, out_tag_16;
    logic        out_valid_16, out_ready_16 = 1'b1;
    logic [16:0] out_res_16;

    arm_shift_pipe #(.WIDTH(32), .AMT_W(8), .TAG_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_is_dpis(in_is_dpis), .in_amt(in_amt),
        .in_data(in_data), .in_c(in_c), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag)
    );

    arm_shift_pipe #(.WIDTH(16), .AMT_W(8), .TAG_W(4)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid_16), .in_ready(in_ready_16),
        .in_type(in_type_16), .in_is_dpis(in_is_dpis_16), .in_amt(in_amt_16),
        .in_data(in_data_16), .in_c(in_c_16), .in_tag(in_tag_16),
        .out_valid(out_valid_16), .out_ready(out_ready_16), .out_res(out_res_16),
        .out_tag(out_tag_16)
    );

    typedef struct packed {
        logic [1:0]  typ;
        logic        dpis;
        logic [7:0]  amt;
        logic [31:0] data;
        logic        c;
        logic [3:0]  tag;
    } op_t;

    int          checks = 0;
    int          errors = 0;
    logic [36:0] sb[$];
    logic        was_stalled = 1'b0;
    logic [32:0] held_res = '0;
    logic [3:0]  held_tag = '0;

    function automatic op_t mk(input logic [1:0] typ, input logic dpis, input logic [7:0] amt,
                               input logic [31:0] data, input logic c, input logic [3:0] tag);
        op_t o;
        o.typ = typ; o.dpis = dpis; o.amt = amt; o.data = data; o.c = c; o.tag = tag;
        return o;
    endfunction

    // Reference model written straight from the ARM shifter rules.
    function automatic logic [32:0] model(input op_t op);
        int          a;
        int          r;
        logic [31:0] d;
        logic [31:0] rv;
        logic [32:0] res;
        d = op.data;
        a = int'(op.amt);
        res = '0;
        if (a == 0 && (!op.dpis || op.typ == SH_LSL)) begin
            res = {op.c, d};
        end else if (a == 0 && op.typ == SH_ROR) begin
            res = {d[0], op.c, d[31:1]};
        end else begin
            if (a == 0) a = 32;
            case (op.typ)
                SH_LSL: begin
                    if (a < 32) res = {d[32-a], d << a};
                    else if (a == 32) res = {d[0], 32'h0};
                    else res = '0;
                end
                SH_LSR: begin
                    if (a < 32) res = {d[a-1], d >> a};
                    else if (a == 32) res = {d[31], 32'h0};
                    else res = '0;
                end
                SH_ASR: begin
                    if (a < 32) begin
                        rv = $unsigned($signed(d) >>> a);
                        res = {d[a-1], rv};
                    end else begin
                        res = {33{d[31]}};
                    end
                end
                default: begin
                    r = a % 32;
                    if (r == 0) begin
                        res = {d[31], d};
                    end else begin
                        rv = (d >> r) | (d << (32 - r));
                        res = {d[r-1], rv};
                    end
                end
            endcase
        end
        return res;
    endfunction

    // One clock of stimulus; called at the falling edge, checks outputs 1 time unit later.
    task automatic step(input logic v, input op_t op, input logic [32:0] exp,
                        input logic rdy, output logic acc);
        logic        exp_rdy;
        logic [36:0] e;
        in_valid = v; in_type = op.typ; in_is_dpis = op.dpis; in_amt = op.amt;
        in_data = op.data; in_c = op.c; in_tag = op.tag; out_ready = rdy;
        #1;
        exp_rdy = !(sb.size() == 2 && !rdy);
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready got %b expected %b (in flight %0d)", in_ready, exp_rdy, sb.size());
        end
        if (was_stalled) begin
            checks++;
            if (out_valid !== 1'b1 || out_res !== held_res || out_tag !== held_tag) begin
                errors++;
                $display("FAIL stall_hold got v=%b %h/%h expected v=1 %h/%h",
                         out_valid, out_res, out_tag, held_res, held_tag);
            end
        end
        if (out_valid === 1'b1 && rdy) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result got %h tag %h expected none", out_res, out_tag);
            end else begin
                e = sb.pop_front();
                if ({out_tag, out_res} !== e) begin
                    errors++;
                    $display("FAIL result got tag %h res %h expected tag %h res %h",
                             out_tag, out_res, e[36:33], e[32:0]);
                end
            end
        end
        acc = v && (in_ready === 1'b1);
        if (acc) sb.push_back({op.tag, exp});
        was_stalled = (out_valid === 1'b1) && !rdy;
        held_res = out_res;
        held_tag = out_tag;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input op_t op, input logic [32:0] exp);
        logic acc;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, op, exp, 1'b1, acc);
            if (acc) return;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout got no accept expected accept within 20 cycles");
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 30 && sb.size() != 0; i++)
            step(1'b0, '0, '0, 1'b1, acc);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", sb.size());
        end
        for (int i = 0; i < 3; i++)
            step(1'b0, '0, '0, 1'b1, acc);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_res !== 33'h0 || out_tag !== 4'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got v=%b res=%h tag=%h rdy=%b expected v=0 res=0 tag=0 rdy=1",
                     out_valid, out_res, out_tag, in_ready);
        end
        checks++;
        if (out_valid_16 !== 1'b0 || out_res_16 !== 17'h0 || in_ready_16 !== 1'b1) begin
            errors++;
            $display("FAIL reset_state_16 got v=%b res=%h rdy=%b expected v=0 res=0 rdy=1",
                     out_valid_16, out_res_16, in_ready_16);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_directed();
        op_t         ops[17];
        logic [32:0] exps[17];
        ops[0]  = mk(SH_LSL, 1'b0, 8'd32,  32'h0000_0001, 1'b0, 4'h0); exps[0]  = 33'h1_0000_0000;
        ops[1]  = mk(SH_LSL, 1'b0, 8'd33,  32'h0000_0001, 1'b0, 4'h1); exps[1]  = 33'h0_0000_0000;
        ops[2]  = mk(SH_LSR, 1'b1, 8'd0,   32'h8000_0000, 1'b0, 4'h2); exps[2]  = 33'h1_0000_0000;
        ops[3]  = mk(SH_ASR, 1'b0, 8'd200, 32'h8000_0000, 1'b0, 4'h3); exps[3]  = 33'h1_FFFF_FFFF;
        ops[4]  = mk(SH_ROR, 1'b1, 8'd0,   32'h0000_0003, 1'b1, 4'h4); exps[4]  = 33'h1_8000_0001;
        ops[5]  = mk(SH_ROR, 1'b0, 8'd64,  32'h8000_0001, 1'b0, 4'h5); exps[5]  = 33'h1_8000_0001;
        ops[6]  = mk(SH_LSL, 1'b0, 8'd0,   32'h1234_5678, 1'b1, 4'h6); exps[6]  = 33'h1_1234_5678;
        ops[7]  = mk(SH_LSR, 1'b0, 8'd0,   32'h1234_5678, 1'b1, 4'h7); exps[7]  = 33'h1_1234_5678;
        ops[8]  = mk(SH_ASR, 1'b0, 8'd0,   32'h1234_5678, 1'b1, 4'h8); exps[8]  = 33'h1_1234_5678;
        ops[9]  = mk(SH_ROR, 1'b0, 8'd0,   32'h1234_5678, 1'b1, 4'h9); exps[9]  = 33'h1_1234_5678;
        ops[10] = mk(SH_LSL, 1'b0, 8'd4,   32'hF000_000F, 1'b0, 4'hA); exps[10] = 33'h1_0000_00F0;
        ops[11] = mk(SH_ASR, 1'b1, 8'd4,   32'h8000_0010, 1'b0, 4'hB); exps[11] = 33'h0_F800_0001;
        ops[12] = mk(SH_ROR, 1'b1, 8'd8,   32'h1234_56AB, 1'b0, 4'hC); exps[12] = 33'h1_AB12_3456;
        ops[13] = mk(SH_ROR, 1'b0, 8'd36,  32'h0000_000F, 1'b0, 4'hD); exps[13] = 33'h1_F000_0000;
        ops[14] = mk(SH_LSL, 1'b1, 8'd0,   32'hDEAD_BEEF, 1'b0, 4'hE); exps[14] = 33'h0_DEAD_BEEF;
        ops[15] = mk(SH_ASR, 1'b1, 8'd0,   32'h4000_0000, 1'b1, 4'hF); exps[15] = 33'h0_0000_0000;
        ops[16] = mk(SH_LSR, 1'b0, 8'd1,   32'h0000_0003, 1'b0, 4'h3); exps[16] = 33'h1_0000_0001;
        for (int i = 0; i < 17; i++)
            send(ops[i], exps[i]);
        drain();
    endtask

    task automatic test_latency();
        op_t  op;
        logic acc;
        op = mk(SH_LSR, 1'b0, 8'd8, 32'hAABB_CCDD, 1'b0, 4'h7);
        step(1'b1, op, 33'h1_00AA_BBCC, 1'b0, acc);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_1 got out_valid %b expected 0", out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_res !== 33'h1_00AA_BBCC) begin
            errors++;
            $display("FAIL latency_2 got v=%b res=%h expected v=1 res=%h",
                     out_valid, out_res, 33'h1_00AA_BBCC);
        end
        was_stalled = 1'b0;
        drain();
    endtask

    task automatic test_back_to_back();
        op_t  ops[32];
        op_t  op;
        logic acc;
        logic v;
        int   idx;
        int   cyc;
        for (int i = 0; i < 32; i++) begin
            ops[i] = mk(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40)),
                        $urandom, 1'($urandom_range(0, 1)), 4'(i));
        end
        idx = 0;
        cyc = 0;
        while ((idx < 32 || sb.size() != 0) && cyc < 600) begin
            v  = (idx < 32) && (idx < 8 || $urandom_range(0, 3) != 0);
            op = (idx < 32) ? ops[idx] : '0;
            step(v, op, model(op), 1'($urandom_range(0, 1)), acc);
            if (acc) idx++;
            cyc++;
        end
        checks++;
        if (idx != 32 || sb.size() != 0) begin
            errors++;
            $display("FAIL stream_done got %0d sent %0d pending expected 32 sent 0 pending", idx, sb.size());
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        logic acc;
        for (int i = 0; i < 3; i++)
            step(1'b1, mk(SH_LSL, 1'b0, 8'd1, 32'h1 << i, 1'b0, 4'(i + 8)),
                 model(mk(SH_LSL, 1'b0, 8'd1, 32'h1 << i, 1'b0, 4'(i + 8))), 1'b0, acc);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_before_reset got v=%b rdy=%b expected v=1 rdy=0", out_valid, in_ready);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_res !== 33'h0 || out_tag !== 4'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midflight_reset got v=%b res=%h tag=%h rdy=%b expected v=0 res=0 tag=0 rdy=1",
                     out_valid, out_res, out_tag, in_ready);
        end
        sb.delete();
        was_stalled = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++)
            step(1'b0, '0, '0, 1'b1, acc);
    endtask

    task automatic w16_op(input logic [1:0] typ, input logic dpis, input logic [7:0] amt,
                          input logic [15:0] data, input logic c, input logic [16:0] exp);
        int lat;
        in_valid_16 = 1'b1; in_type_16 = typ; in_is_dpis_16 = dpis; in_amt_16 = amt;
        in_data_16 = data; in_c_16 = c; in_tag_16 = 4'h5; out_ready_16 = 1'b1;
        #1;
        checks++;
        if (in_ready_16 !== 1'b1) begin
            errors++;
            $display("FAIL w16_ready got %b expected 1", in_ready_16);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid_16 = 1'b0;
        lat = 1;
        while (lat < 10) begin
            #1;
            if (out_valid_16 === 1'b1) break;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 2 || out_res_16 !== exp || out_tag_16 !== 4'h5) begin
            errors++;
            $display("FAIL w16_result got lat=%0d res=%h tag=%h expected lat=2 res=%h tag=5",
                     lat, out_res_16, out_tag_16, exp);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_width16();
        w16_op(SH_LSL, 1'b0, 8'd16, 16'h0001, 1'b0, 17'h1_0000);
        w16_op(SH_LSL, 1'b0, 8'd17, 16'h0001, 1'b0, 17'h0_0000);
        w16_op(SH_ROR, 1'b0, 8'd20, 16'h000F, 1'b0, 17'h1_F000);
        w16_op(SH_ASR, 1'b1, 8'd0,  16'h8000, 1'b0, 17'h1_FFFF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_latency();
        test_back_to_back();
        test_reset_midflight();
        test_width16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
